// File: rtl/issue_scheduler.sv
// issue_scheduler: single-entry decode/hold stage that captures operands, tracks CDB wakeups
// and dispatches round-robin to reservation stations. Optional stall counters: ISSUE_PERF_CNT_EN.
module issue_scheduler #(
  parameter int NUM_RS = 4,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_imm,
  input  logic              in_pred,
  input  logic              in_branch,
  input  logic              in_jump,
  output logic [4:0]        rf_rs1,
  output logic [4:0]        rf_rs2,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  input  logic [TAG_W-1:0]  q_j,
  input  logic [TAG_W-1:0]  q_k,
  input  logic [NUM_RS-1:0] rs_busy,
  input  logic [TAG_W-1:0]  rob_tag,
  input  logic              rob_full,
  input  logic              lsq_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [31:0]       cdb_value,
  input  logic              flush,
  output logic              disp_valid,
  output logic [NUM_RS-1:0] disp_sel,
  output logic [31:0]       disp_vj,
  output logic [31:0]       disp_vk,
  output logic [TAG_W-1:0]  disp_qj,
  output logic [TAG_W-1:0]  disp_qk,
  output logic [2:0]        disp_alu_op,
  output logic [1:0]        disp_br_type,
  output logic [TAG_W-1:0]  disp_rob_tag,
  output logic [1:0]        disp_rob_type,
  output logic [4:0]        disp_dest,
  output logic              disp_writes,
  output logic              disp_lsq_load,
  output logic              disp_lsq_store
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_rob_cnt,
  output logic [31:0]       stall_rs_cnt,
  output logic [31:0]       stall_lsq_cnt
`endif
);

  localparam int PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [2:0]       alu_op;
    logic [1:0]       br_type;
    logic [1:0]       rob_type;
    logic [4:0]       dest;
    logic             writes;
    logic             is_load;
    logic             is_store;
  } entry_t;

  logic             hold_valid;
  entry_t           held;
  entry_t           cur;
  entry_t           new_entry;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] chosen;
  logic [PTR_W-1:0] next_ptr;
  logic             free_rs;
  logic             needs_lsq;
  logic             fire;
  logic             accept;

  // Branch prediction info and the pre-decoded immediate are carried by other stages.
  logic unused_inputs;
  assign unused_inputs = ^{in_imm, in_pred, in_branch};

  assign rf_rs1 = in_instr[19:15];
  assign rf_rs2 = in_instr[24:20];

  // Decode and operand capture for the instruction being accepted this cycle.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_r, is_imm_alu, is_load, is_store, is_branch, is_jump;
  logic        hit_j, hit_k;
  logic [31:0] src1_v, src2_v;
  logic [31:0] i_imm, s_imm;

  assign opcode     = in_instr[6:0];
  assign funct3     = in_instr[14:12];
  assign funct7     = in_instr[31:25];
  assign is_jump    = in_jump;
  assign is_r       = ~is_jump & (opcode == OP_R);
  assign is_imm_alu = ~is_jump & (opcode == OP_I);
  assign is_load    = ~is_jump & (opcode == OP_LOAD);
  assign is_store   = ~is_jump & (opcode == OP_STORE);
  assign is_branch  = ~is_jump & (opcode == OP_BRANCH);
  assign i_imm      = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};

  assign hit_j  = cdb_valid && (q_j != '0) && (cdb_tag == q_j);
  assign hit_k  = cdb_valid && (q_k != '0) && (cdb_tag == q_k);
  assign src1_v = (q_j == '0) ? rs1_data : (hit_j ? cdb_value : 32'd0);
  assign src2_v = (q_k == '0) ? rs2_data : (hit_k ? cdb_value : 32'd0);

  // NOTE: every field gets a default before any branch so no path leaves a latch behind.
  always_comb begin
    new_entry          = '0;
    new_entry.vj       = src1_v;
    new_entry.qj       = hit_j ? '0 : q_j;
    new_entry.vk       = src2_v;
    new_entry.qk       = hit_k ? '0 : q_k;
    new_entry.dest     = in_instr[11:7];
    new_entry.is_load  = is_load;
    new_entry.is_store = is_store;
    new_entry.writes   = ~(is_branch | is_store);

    if (is_jump) begin
      new_entry.vj = in_pc;
      new_entry.qj = '0;
      new_entry.vk = 32'd4;
      new_entry.qk = '0;
    end else if (is_imm_alu || is_load) begin
      new_entry.vk = i_imm;
      new_entry.qk = '0;
    end else if (is_store) begin
      new_entry.vk = s_imm;
      new_entry.qk = '0;
    end

    if (is_r) begin
      if (funct7 == 7'b0000001) begin
        case (funct3)
          3'b000:  new_entry.alu_op = 3'b100;
          3'b001:  new_entry.alu_op = 3'b101;
          3'b100:  new_entry.alu_op = 3'b011;
          3'b111:  new_entry.alu_op = 3'b010;
          default: new_entry.alu_op = 3'b001;
        endcase
      end else if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
        new_entry.alu_op = 3'b000;
      end else begin
        new_entry.alu_op = 3'b001;
      end
    end else if (is_branch) begin
      new_entry.alu_op = 3'b001;
    end

    if (is_branch) begin
      case (funct3)
        3'b000:  new_entry.br_type = 2'b10;
        3'b001:  new_entry.br_type = 2'b01;
        default: new_entry.br_type = 2'b11;
      endcase
    end

    if (is_branch)     new_entry.rob_type = 2'b00;
    else if (is_store) new_entry.rob_type = 2'b01;
    else if (is_load)  new_entry.rob_type = 2'b11;
    else               new_entry.rob_type = 2'b10;
  end

  // Held entry with any matching CDB broadcast folded in; feeds both outputs and the register.
  always_comb begin
    cur = held;
    if (cdb_valid && (held.qj != '0) && (cdb_tag == held.qj)) begin
      cur.vj = cdb_value;
      cur.qj = '0;
    end
    if (cdb_valid && (held.qk != '0) && (cdb_tag == held.qk)) begin
      cur.vk = cdb_value;
      cur.qk = '0;
    end
  end

  // Round-robin: scanning downward leaves the first free RS at or after rr_ptr.
  always_comb begin
    int idx;
    idx     = 0;
    free_rs = 1'b0;
    chosen  = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_RS) idx = idx - NUM_RS;
      if (!rs_busy[idx[PTR_W-1:0]]) begin
        free_rs = 1'b1;
        chosen  = idx[PTR_W-1:0];
      end
    end
  end

  assign next_ptr  = (int'(chosen) == NUM_RS - 1) ? '0 : chosen + 1'b1;
  assign needs_lsq = held.is_load | held.is_store;
  assign fire      = hold_valid & ~flush & ~rob_full & free_rs & ~(needs_lsq & lsq_full);
  assign in_ready  = ~flush & (~hold_valid | fire);
  assign accept    = in_valid & in_ready;

  // NOTE: held fields are reset along with hold_valid so the disp_* buses are defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      held       <= '0;
      rr_ptr     <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values of the others.
      if (accept) begin
        hold_valid <= 1'b1;
        held       <= new_entry;
      end else if (fire || flush) begin
        hold_valid <= 1'b0;
      end else if (hold_valid) begin
        held <= cur;
      end
      if (fire) rr_ptr <= next_ptr;
    end
  end

  assign disp_valid     = fire;
  assign disp_sel       = fire ? ({{(NUM_RS-1){1'b0}}, 1'b1} << chosen) : '0;
  assign disp_vj        = cur.vj;
  assign disp_vk        = cur.vk;
  assign disp_qj        = cur.qj;
  assign disp_qk        = cur.qk;
  assign disp_alu_op    = cur.alu_op;
  assign disp_br_type   = cur.br_type;
  assign disp_rob_tag   = rob_tag;
  assign disp_rob_type  = cur.rob_type;
  assign disp_dest      = cur.dest;
  assign disp_writes    = cur.writes;
  assign disp_lsq_load  = fire & cur.is_load;
  assign disp_lsq_store = fire & cur.is_store;

`ifdef ISSUE_PERF_CNT_EN
  // Each stalled cycle is charged to the first blocking resource only.
  logic stalled;
  assign stalled = hold_valid & ~fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_rob_cnt <= '0;
      stall_rs_cnt  <= '0;
      stall_lsq_cnt <= '0;
    end else if (stalled) begin
      if (rob_full) begin
        if (stall_rob_cnt != '1) stall_rob_cnt <= stall_rob_cnt + 32'd1;
      end else if (!free_rs) begin
        if (stall_rs_cnt != '1) stall_rs_cnt <= stall_rs_cnt + 32'd1;
      end else if (needs_lsq && lsq_full) begin
        if (stall_lsq_cnt != '1) stall_lsq_cnt <= stall_lsq_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
